// File: rtl/acc_layer_sequencer.sv
// Two-layer inference sequencer: drives SRAM read addressing, collects class scores, runs argmax.
// Optional score-wait timeout is enabled by defining SEQ_TIMEOUT_EN.
module acc_layer_sequencer #(
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned L1_ROWS  = 100,
   parameter int unsigned L2A_BASE = 100,
   parameter int unsigned L2B_BASE = 110,
   parameter int unsigned N_CLASS  = 10,
   parameter int unsigned SCORE_W  = 16,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      split,
   output logic                      weight_we,
   output logic [ADDR_W-1:0]         weight_addr,
   output logic                      input_we,
   output logic [ADDR_W-1:0]         input_addr,
   output logic                      mac_clr,
   output logic                      mac_en,
   output logic                      layer_sel,
   output logic                      lane_sel,
   input  logic                      score_vld,
   input  logic signed [SCORE_W-1:0] score,
   output logic                      busy,
   output logic                      valid,
   output logic [3:0]                inference_result,
   output logic [3:0]                result_b,
   output logic                      err
);

   localparam int unsigned CNT_W = $clog2(L1_ROWS + 1);
   localparam int unsigned SC_W  = $clog2(N_CLASS + 1);

   // The timeout compare fires one cycle early so DONE lands exactly TIMEOUT cycles after a score.
   if (TIMEOUT < 2) begin : g_timeout_chk
      $error("TIMEOUT must be at least 2");
   end

   typedef enum logic [2:0] {StIdle, StL1, StL2, StWait, StDone} state_e;

   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       split_q, split_d;
   logic                       lane_q, lane_d;
   logic [ADDR_W-1:0]          waddr_q, waddr_d;
   logic [ADDR_W-1:0]          iaddr_q, iaddr_d;
   logic                       mac_clr_q, mac_clr_d;
   logic                       mac_en_q, mac_en_d;
   logic                       layer_sel_q, layer_sel_d;
   logic                       lane_sel_q, lane_sel_d;
   logic [SC_W-1:0]            score_cnt_q, score_cnt_d;
   logic signed [SCORE_W-1:0]  max_q, max_d;
   logic [3:0]                 res_a_q, res_a_d;
   logic [3:0]                 res_b_q, res_b_d;

   logic accept, issue, l1_last, l2_last, score_take, scores_done, timeout_hit, enter_l2;
   logic [ADDR_W-1:0] l2_base;

   assign accept      = (state_q == StIdle) && start;
   assign issue       = (state_q == StL1) || ((state_q == StL2) && (cnt_q != '0));
   assign l1_last     = (state_q == StL1) && (cnt_q == CNT_W'(L1_ROWS - 1));
   assign l2_last     = (state_q == StL2) && (cnt_q == CNT_W'(N_CLASS));
   assign scores_done = (score_cnt_q == SC_W'(N_CLASS));
   assign score_take  = score_vld && ((state_q == StL2) || (state_q == StWait)) && !scores_done;
   assign l2_base     = lane_q ? ADDR_W'(L2B_BASE) : ADDR_W'(L2A_BASE);

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   assign timeout_hit = (state_q == StWait) && !scores_done && !score_vld &&
                        (tmo_q == TMO_W'(TIMEOUT - 2));

   always_comb begin
      tmo_d = tmo_q;
      err_d = err_q;
      if (score_vld || ((state_d == StWait) && (state_q != StWait))) begin
         tmo_d = '0;
      end else if (state_q == StWait) begin
         tmo_d = tmo_q + 1'b1;
      end
      if (accept) begin
         err_d = 1'b0;
      end else if (timeout_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StL1;
         StL1:   if (l1_last) state_d = StL2;
         StL2:   if (l2_last) state_d = StWait;
         StWait: begin
            if (scores_done) begin
               state_d = (split_q && !lane_q) ? StL2 : StDone;
            end else if (timeout_hit) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy  = (state_q == StL1) || (state_q == StL2) || (state_q == StWait);
      valid = (state_q == StDone);
   end

   assign enter_l2 = (state_d == StL2) && (state_q != StL2);

   always_comb begin
      cnt_d       = '0;
      split_d     = accept ? split : split_q;
      lane_d      = lane_q;
      waddr_d     = waddr_q;
      iaddr_d     = iaddr_q;
      mac_clr_d   = accept || enter_l2;
      mac_en_d    = issue;
      layer_sel_d = issue && (state_q == StL2);
      lane_sel_d  = issue && lane_q;
      score_cnt_d = score_cnt_q;
      max_d       = max_q;
      res_a_d     = res_a_q;
      res_b_d     = res_b_q;

      if (accept) begin
         lane_d  = 1'b0;
         waddr_d = '0;
         iaddr_d = '0;
         res_a_d = '0;
         res_b_d = '0;
      end

      if (state_q == StL1 && !l1_last) begin
         cnt_d   = cnt_q + 1'b1;
         waddr_d = ADDR_W'(cnt_q) + 1'b1;
         iaddr_d = ADDR_W'(cnt_q) + 1'b1;
      end

      // cnt 0 is the clear cycle; cnt j issues base + j - 1, input address held from layer 1
      if (state_q == StL2 && !l2_last) begin
         cnt_d   = cnt_q + 1'b1;
         waddr_d = (cnt_q == '0) ? l2_base : waddr_q + 1'b1;
      end

      if (state_q == StWait && scores_done && split_q && !lane_q) begin
         lane_d = 1'b1;
      end

      if (accept || enter_l2) begin
         score_cnt_d = '0;
      end else if (score_take) begin
         score_cnt_d = score_cnt_q + 1'b1;
         // Strictly-greater keeps the lowest index on ties
         if (score_cnt_q == '0 || score > max_q) begin
            max_d = score;
            if (lane_q) begin
               res_b_d = 4'(score_cnt_q);
            end else begin
               res_a_d = 4'(score_cnt_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         split_q     <= 1'b0;
         lane_q      <= 1'b0;
         waddr_q     <= '0;
         iaddr_q     <= '0;
         mac_clr_q   <= 1'b0;
         mac_en_q    <= 1'b0;
         layer_sel_q <= 1'b0;
         lane_sel_q  <= 1'b0;
         score_cnt_q <= '0;
         max_q       <= '0;
         res_a_q     <= '0;
         res_b_q     <= '0;
      end else begin
         cnt_q       <= cnt_d;
         split_q     <= split_d;
         lane_q      <= lane_d;
         waddr_q     <= waddr_d;
         iaddr_q     <= iaddr_d;
         mac_clr_q   <= mac_clr_d;
         mac_en_q    <= mac_en_d;
         layer_sel_q <= layer_sel_d;
         lane_sel_q  <= lane_sel_d;
         score_cnt_q <= score_cnt_d;
         max_q       <= max_d;
         res_a_q     <= res_a_d;
         res_b_q     <= res_b_d;
      end
   end

   assign weight_we        = 1'b0;
   assign input_we         = 1'b0;
   assign weight_addr      = waddr_q;
   assign input_addr       = iaddr_q;
   assign mac_clr          = mac_clr_q;
   assign mac_en           = mac_en_q;
   assign layer_sel        = layer_sel_q;
   assign lane_sel         = lane_sel_q;
   assign inference_result = res_a_q;
   assign result_b         = res_b_q;

endmodule
